// File: rtl/game_pkg.sv
// Shared game-flow definitions: the 2-bit game-state encoding consumed by the
// controller, renderer, scorer and audio blocks.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10,
        ST_WIN  = 2'b11
    } game_state_e;

    localparam int unsigned GAME_STATE_W = 2;

endpackage : game_pkg

// File: rtl/state_fsm_if.sv
// Control/status strobes into the game-flow controller and its published state.
// The master side belongs to the input/game logic, the slave side to the controller.
interface state_fsm_if;
    import game_pkg::*;

    logic                    start;
    logic                    restart;
    logic                    over;
    logic                    success;
    logic [GAME_STATE_W-1:0] state;

    modport master (
        output start,
        output restart,
        output over,
        output success,
        input  state
    );

    modport slave (
        input  start,
        input  restart,
        input  over,
        input  success,
        output state
    );

endinterface : state_fsm_if

// File: rtl/state_fsm.sv
// Game-flow controller: title -> play -> lose/win -> title. Moore machine whose
// state register drives the published game state directly.
module state_fsm
    import game_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    state_fsm_if.slave   ctrl
);

    // Initialiser gives a valid title-screen state even if rst never asserts.
    game_state_e state_q = ST_IDLE;
    game_state_e state_d;

    // State register; rst dominates every strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state rules; restart wins from any state, lose/win are sticky.
    always_comb begin
        state_d = state_q;
        if (ctrl.restart) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctrl.start) begin
                        state_d = ST_PLAY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (ctrl.over) begin
                        state_d = ST_OVER;
                    end else if (ctrl.success) begin
                        state_d = ST_WIN;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_OVER: state_d = ST_OVER;
                ST_WIN:  state_d = ST_WIN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ctrl.state = state_q;

endmodule : state_fsm

// File: tb/tb_state_fsm.sv
// Self-checking bench for state_fsm: directed scenarios followed by random
// strobes, all compared against a rule-level reference model.
module tb_state_fsm;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   model_state;

    state_fsm_if bus ();

    state_fsm dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.slave)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_val(input string tag, input logic [1:0] got, input logic [1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    // Reference: game rules as written, states as plain integers 0..3.
    function automatic int ref_next(input int s, input bit r, input bit st, input bit rs,
                                    input bit ov, input bit sc);
        if (r || rs)  return 0;
        if (s == 0)   return st ? 1 : 0;
        if (s == 1)   return ov ? 2 : (sc ? 3 : 1);
        return s;
    endfunction

    task automatic step(input string tag, input bit r, input bit st, input bit rs,
                        input bit ov, input bit sc);
        int exp;
        @(negedge clk);
        rst         = r;
        bus.start   = st;
        bus.restart = rs;
        bus.over    = ov;
        bus.success = sc;
        exp = ref_next(model_state, r, st, rs, ov, sc);
        @(posedge clk);
        #1;
        model_state = exp;
        check_val(tag, bus.state, exp[1:0]);
    endtask

    initial begin
        int m;
        total = 0;
        bad   = 0;
        model_state = 0;
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.restart = 1'b0;
        bus.over    = 1'b0;
        bus.success = 1'b0;

        #5;
        check_val("powerup", bus.state, 2'b00);

        // 1: reset, then over/success ignored in IDLE
        step("t1_rst",      1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t1_idle_ign", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        // 2: start enters PLAY and holds
        step("t2_start",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t2_hold",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // 3: win, sticky, restart
        step("t3_win",      1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t3_win_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("t3_win_ign",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("t3_restart",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // 4: lose, restart, start again
        step("t4_play",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t4_over",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("t4_ovr_ign",  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("t4_restart",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t4_start",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // 5: over beats success
        step("t5_both",     1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("t5_restart",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        // 6: restart from PLAY, start masked by restart, rst from WIN
        step("t6_play",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t6_restart",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t6_st_rs",    1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("t6_st_rs2",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("t6_play2",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t6_start_hd", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t6_win",      1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("t6_rst_win",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random strobes: restart/rst kept rare so PLAY/OVER/WIN get exercised.
        for (int i = 0; i < 400; i++) begin
            m = $urandom_range(0, 99);
            step("rand",
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 5) == 0),
                 (m < 20));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_state_fsm
